eq_fir_seq_ctrl: RTL and testbench

//  Sequences one stereo FIR band: takes the codec's new-sample strobe, issues wrt_smpl to the

---
 rtl/eq_fir_seq_if.sv | 53 +++++
 rtl/eq_fir_seq_ctrl.sv | 178 +++++++++++++++++
 tb/tb_eq_fir_seq_ctrl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/eq_fir_seq_if.sv
// ---------------------------------------------------------------------------
// eq_fir_seq_if
//   Handshake bundle between the codec/queue side and the per-band FIR
//   sequencer.
//
//   master : the codec/queue side. Drives vld, seq_lft, seq_rht and clr_err.
//            Observes the sequencer's strobes, address and flags.
//   slave  : the sequencer itself (eq_fir_seq_ctrl).
//
//   Signals
//     vld        codec new-sample strobe (1 cycle)
//     seq_lft    left queue sequencing flag
//     seq_rht    right queue sequencing flag
//     clr_err    clear sticky error flags (1 cycle)
//     wrt_smpl   write strobe to both sample queues
//     coeff_addr coefficient ROM address (ROM output is registered)
//     mac_clr    clear both channel accumulators
//     mac_en     accumulate this cycle
//     res_vld    accumulators hold a complete, valid result (1 cycle)
//     busy       sequencer is not idle
//     err_ovr    sticky: sample strobe arrived while busy
//     err_sync   sticky: left/right sequencing flags disagreed
//     err_len    sticky: burst length differed from the tap count
// ---------------------------------------------------------------------------
interface eq_fir_seq_if #(
  parameter int ADDR_W = 10
);
  logic              vld;
  logic              seq_lft;
  logic              seq_rht;
  logic              clr_err;
  logic              wrt_smpl;
  logic [ADDR_W-1:0] coeff_addr;
  logic              mac_clr;
  logic              mac_en;
  logic              res_vld;
  logic              busy;
  logic              err_ovr;
  logic              err_sync;
  logic              err_len;

  modport master (
    output vld, seq_lft, seq_rht, clr_err,
    input  wrt_smpl, coeff_addr, mac_clr, mac_en, res_vld, busy,
           err_ovr, err_sync, err_len
  );

  modport slave (
    input  vld, seq_lft, seq_rht, clr_err,
    output wrt_smpl, coeff_addr, mac_clr, mac_en, res_vld, busy,
           err_ovr, err_sync, err_len
  );
endinterface

// File: rtl/eq_fir_seq_ctrl.sv
// ---------------------------------------------------------------------------
// eq_fir_seq_ctrl
//   Sequencer for one stereo FIR band. On each codec sample strobe it writes
//   the new sample pair into the left/right queues, waits for the queues to
//   start their common readout burst, steps the shared coefficient ROM
//   address in step with that burst and drives the MAC clear/enable. After
//   the burst it flags a valid result when the burst had the right length
//   and both queues stayed in lockstep. It holds no data path of its own.
//
//   Ports
//     clk    system clock
//     rst_n  asynchronous active-low reset
//     bus    eq_fir_seq_if.slave (strobes, ROM address, MAC control, flags)
//
//   Every output is a flop; the combinational blocks compute next values.
// ---------------------------------------------------------------------------
module eq_fir_seq_ctrl #(
  parameter int NUM_TAPS = 1021,
  parameter int ADDR_W   = 10,
  parameter int SEQ_TMO  = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  eq_fir_seq_if.slave bus
);

  localparam int TAP_W = ADDR_W + 1;
  localparam int TMO_W = $clog2(SEQ_TMO + 1);

  localparam logic [TAP_W-1:0]  TAPS_FULL = TAP_W'(NUM_TAPS);
  localparam logic [TAP_W-1:0]  TAPS_MAX  = '1;
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_TAPS - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(SEQ_TMO - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ACC,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next_state;

  logic [TMO_W-1:0]  r_tmo;
  logic [TAP_W-1:0]  r_taps;
  logic              r_burst_skew;

  logic              r_wrt_smpl,   w_wrt_smpl_nxt;
  logic [ADDR_W-1:0] r_coeff_addr, w_coeff_addr_nxt;
  logic              r_mac_clr,    w_mac_clr_nxt;
  logic              r_mac_en,     w_mac_en_nxt;
  logic              r_res_vld,    w_res_vld_nxt;
  logic              r_busy,       w_busy_nxt;
  logic              r_err_ovr,    w_err_ovr_nxt;
  logic              r_err_sync,   w_err_sync_nxt;
  logic              r_err_len,    w_err_len_nxt;

  // The burst is only trusted when both queues agree; any disagreement is
  // an error and the AND keeps the sequencer from running ahead of either.
  logic w_seq;
  logic w_skew;
  logic w_accept;

  assign w_seq    = bus.seq_lft & bus.seq_rht;
  assign w_skew   = bus.seq_lft ^ bus.seq_rht;
  assign w_accept = (r_state == S_IDLE) && bus.vld;

  // ---------------------------------------------------------------- state
  // NOTE: every clocked block uses non-blocking assignments so all flops
  // sample the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // ----------------------------------------------------------- next state
  // NOTE: each always_comb assigns a default first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.vld) w_next_state = S_WAIT;
      // A late seq on the final wait cycle still starts the burst.
      S_WAIT:  if (w_seq)                  w_next_state = S_ACC;
               else if (r_tmo == TMO_LAST) w_next_state = S_IDLE;
      S_ACC:   if (!w_seq) w_next_state = S_DRAIN;
      S_DRAIN: w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // ----------------------------------------------------- counters/tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo        <= '0;
      r_taps       <= '0;
      r_burst_skew <= 1'b0;
    end else begin
      r_tmo <= (r_state == S_WAIT && w_next_state == S_WAIT) ? r_tmo + 1'b1 : '0;

      if (w_accept)
        r_taps <= '0;
      else if (r_state == S_WAIT && w_seq)
        r_taps <= TAP_W'(1);
      else if (r_state == S_ACC && w_seq && r_taps != TAPS_MAX)
        r_taps <= r_taps + 1'b1;

      // Skew is tracked per burst so only the affected result is suppressed.
      if (r_state == S_IDLE) r_burst_skew <= 1'b0;
      else if (w_skew)       r_burst_skew <= 1'b1;
    end
  end

  // --------------------------------------------------------- output logic
  always_comb begin
    w_wrt_smpl_nxt   = w_accept;
    w_mac_clr_nxt    = w_accept;
    // One-cycle delay of seq lines the enable up with the registered ROM
    // word and the queue's registered sample output.
    w_mac_en_nxt     = w_seq && (r_state == S_WAIT || r_state == S_ACC);
    w_res_vld_nxt    = (r_state == S_DRAIN) && (r_taps == TAPS_FULL) &&
                       !(r_burst_skew || w_skew);
    w_busy_nxt       = (w_next_state != S_IDLE);

    w_coeff_addr_nxt = r_coeff_addr;
    if (w_accept)
      w_coeff_addr_nxt = '0;
    else if (r_state == S_WAIT && w_seq)
      w_coeff_addr_nxt = ADDR_ONE;
    else if (r_state == S_ACC && w_seq && r_coeff_addr != ADDR_LAST)
      w_coeff_addr_nxt = r_coeff_addr + 1'b1;

    // A new error event outranks a simultaneous clear.
    w_err_ovr_nxt  = (bus.vld && r_state != S_IDLE) || (r_err_ovr && !bus.clr_err);
    w_err_sync_nxt = w_skew || (r_err_sync && !bus.clr_err);
    w_err_len_nxt  = (r_state == S_DRAIN && r_taps != TAPS_FULL) ||
                     (r_err_len && !bus.clr_err);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrt_smpl   <= 1'b0;
      r_coeff_addr <= '0;
      r_mac_clr    <= 1'b0;
      r_mac_en     <= 1'b0;
      r_res_vld    <= 1'b0;
      r_busy       <= 1'b0;
      r_err_ovr    <= 1'b0;
      r_err_sync   <= 1'b0;
      r_err_len    <= 1'b0;
    end else begin
      r_wrt_smpl   <= w_wrt_smpl_nxt;
      r_coeff_addr <= w_coeff_addr_nxt;
      r_mac_clr    <= w_mac_clr_nxt;
      r_mac_en     <= w_mac_en_nxt;
      r_res_vld    <= w_res_vld_nxt;
      r_busy       <= w_busy_nxt;
      r_err_ovr    <= w_err_ovr_nxt;
      r_err_sync   <= w_err_sync_nxt;
      r_err_len    <= w_err_len_nxt;
    end
  end

  assign bus.wrt_smpl   = r_wrt_smpl;
  assign bus.coeff_addr = r_coeff_addr;
  assign bus.mac_clr    = r_mac_clr;
  assign bus.mac_en     = r_mac_en;
  assign bus.res_vld    = r_res_vld;
  assign bus.busy       = r_busy;
  assign bus.err_ovr    = r_err_ovr;
  assign bus.err_sync   = r_err_sync;
  assign bus.err_len    = r_err_len;

endmodule

// File: tb/tb_eq_fir_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_eq_fir_seq_ctrl
//   Bench for eq_fir_seq_ctrl. Queue sequencing is driven from a table of
//   burst shapes relative to the vld cycle T (cycle k = T+k). Expected
//   res_vld cycles go into a queue when vld is driven; a negedge monitor
//   pops them as res_vld pulses appear. Reset, queue fill and mid-burst
//   reset are hand-written sequences.
// ---------------------------------------------------------------------------
module tb_eq_fir_seq_ctrl;

  localparam int NUM_TAPS = 1021;
  localparam int ADDR_W   = 10;
  localparam int SEQ_TMO  = 3;
  localparam int N_FILL   = 1531;
  localparam int N_ROWS   = 10;

  typedef struct packed {
    int ls;        // seq_lft first cycle (k)
    int ll;        // seq_lft length
    int rs;        // seq_rht first cycle
    int rl;        // seq_rht length
    int ovr_k;     // cycle of extra vld (0 = none)
    int clr_k;     // cycle of clr_err (0 = none)
    int exp_mac;   // expected mac_en cycles
    bit exp_res;   // expected res_vld pulse
    bit exp_ovr;
    bit exp_sync;
    bit exp_len;
    bit timing;    // check the cycle-exact latency points
  } burst_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   n_wrt = 0;
  int   n_mac = 0;
  int   n_res = 0;
  int   sb_q[$];

  eq_fir_seq_if #(.ADDR_W(ADDR_W)) bus ();

  eq_fir_seq_ctrl #(
    .NUM_TAPS(NUM_TAPS),
    .ADDR_W  (ADDR_W),
    .SEQ_TMO (SEQ_TMO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard side: count strobes and match res_vld against expected cycles.
  always @(negedge clk) begin
    if (bus.wrt_smpl === 1'b1) n_wrt = n_wrt + 1;
    if (bus.mac_en === 1'b1)   n_mac = n_mac + 1;
    if (bus.res_vld === 1'b1) begin
      n_res = n_res + 1;
      if (sb_q.size() == 0) check("res_vld_unexpected", 1, 0);
      else                  check("res_vld_cycle", cyc, sb_q.pop_front());
    end
  end

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic burst_t mk(input int ls, input int ll, input int rs, input int rl,
                                input int ovr_k, input int clr_k, input int exp_mac,
                                input bit exp_res, input bit exp_ovr, input bit exp_sync,
                                input bit exp_len, input bit timing);
    burst_t b;
    b.ls = ls; b.ll = ll; b.rs = rs; b.rl = rl;
    b.ovr_k = ovr_k; b.clr_k = clr_k; b.exp_mac = exp_mac;
    b.exp_res = exp_res; b.exp_ovr = exp_ovr; b.exp_sync = exp_sync;
    b.exp_len = exp_len; b.timing = timing;
    return b;
  endfunction

  task automatic clear_and_check(input string nm);
    @(negedge clk);
    bus.vld = 1'b0; bus.seq_lft = 1'b0; bus.seq_rht = 1'b0; bus.clr_err = 1'b1;
    @(negedge clk);
    bus.clr_err = 1'b0;
    check({nm, "_flags_cleared"}, {29'd0, bus.err_ovr, bus.err_sync, bus.err_len}, 0);
  endtask

  task automatic run_burst(input burst_t b, input string nm);
    int w0, m0, r0, t0, last, exp_addr;
    last = ((b.ls + b.ll) > (b.rs + b.rl) ? (b.ls + b.ll) : (b.rs + b.rl)) + 4;
    @(negedge clk);
    w0 = n_wrt; m0 = n_mac; r0 = n_res;
    if (b.timing) check({nm, "_busy_k0"}, bus.busy, 0);
    bus.vld = 1'b1;
    t0 = cyc;
    if (b.exp_res) sb_q.push_back(t0 + b.ls + b.ll + 2);
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      bus.vld     = (k == b.ovr_k);
      bus.clr_err = (k == b.clr_k);
      bus.seq_lft = (k >= b.ls) && (k < b.ls + b.ll);
      bus.seq_rht = (k >= b.rs) && (k < b.rs + b.rl);
      if (b.timing) begin
        if (k == 1) begin
          check({nm, "_wrt_k1"}, bus.wrt_smpl, 1);
          check({nm, "_clr_k1"}, bus.mac_clr, 1);
          check({nm, "_busy_k1"}, bus.busy, 1);
        end
        if (k == 2) begin
          check({nm, "_wrt_k2"}, bus.wrt_smpl, 0);
          check({nm, "_addr_k2"}, bus.coeff_addr, 0);
          check({nm, "_macen_k2"}, bus.mac_en, 0);
        end
        if (k == 3) begin
          check({nm, "_macen_k3"}, bus.mac_en, 1);
          check({nm, "_addr_k3"}, bus.coeff_addr, 1);
        end
        if (k == NUM_TAPS + 1) check({nm, "_addr_last"}, bus.coeff_addr, NUM_TAPS - 1);
        if (k == NUM_TAPS + 2) begin
          check({nm, "_addr_sat"}, bus.coeff_addr, NUM_TAPS - 1);
          check({nm, "_macen_lasttap"}, bus.mac_en, 1);
        end
        if (k == NUM_TAPS + 3) check({nm, "_macen_off"}, bus.mac_en, 0);
        if (k == NUM_TAPS + 4) check({nm, "_busy_done"}, bus.busy, 1);
        if (k == NUM_TAPS + 5) check({nm, "_busy_idle"}, bus.busy, 0);
      end
    end
    #1;
    exp_addr = (b.exp_mac < NUM_TAPS - 1) ? b.exp_mac : NUM_TAPS - 1;
    check({nm, "_wrt_count"}, n_wrt - w0, 1);
    check({nm, "_mac_count"}, n_mac - m0, b.exp_mac);
    check({nm, "_res_count"}, n_res - r0, b.exp_res);
    check({nm, "_coeff_addr"}, bus.coeff_addr, exp_addr);
    check({nm, "_err_ovr"}, bus.err_ovr, b.exp_ovr);
    check({nm, "_err_sync"}, bus.err_sync, b.exp_sync);
    check({nm, "_err_len"}, bus.err_len, b.exp_len);
    check({nm, "_busy_end"}, bus.busy, 0);
    clear_and_check(nm);
  endtask

  initial begin
    burst_t      tbl[N_ROWS];
    string       names[N_ROWS];
    logic [31:0] outs;
    int          w0, m0, r0;

    names[0] = "normal";      tbl[0] = mk(2, NUM_TAPS, 2, NUM_TAPS, 0, 0, NUM_TAPS, 1, 0, 0, 0, 1);
    names[1] = "ovr_acc";     tbl[1] = mk(2, NUM_TAPS, 2, NUM_TAPS, 500, 0, NUM_TAPS, 1, 1, 0, 0, 0);
    names[2] = "ovr_done";    tbl[2] = mk(2, NUM_TAPS, 2, NUM_TAPS, NUM_TAPS + 4, 0, NUM_TAPS, 1, 1, 0, 0, 0);
    names[3] = "skew";        tbl[3] = mk(2, NUM_TAPS, 3, NUM_TAPS, 0, 0, NUM_TAPS - 1, 0, 0, 1, 1, 0);
    names[4] = "short";       tbl[4] = mk(2, 1000, 2, 1000, 0, 0, 1000, 0, 0, 0, 1, 0);
    names[5] = "good_after";  tbl[5] = mk(2, NUM_TAPS, 2, NUM_TAPS, 0, 0, NUM_TAPS, 1, 0, 0, 0, 0);
    names[6] = "long";        tbl[6] = mk(2, 1100, 2, 1100, 0, 0, 1100, 0, 0, 0, 1, 0);
    names[7] = "clr_vs_err";  tbl[7] = mk(2, NUM_TAPS, 2, NUM_TAPS, 500, 500, NUM_TAPS, 1, 1, 0, 0, 0);
    names[8] = "late_seq";    tbl[8] = mk(3, NUM_TAPS, 3, NUM_TAPS, 0, 0, NUM_TAPS, 1, 0, 0, 0, 0);
    names[9] = "too_late";    tbl[9] = mk(4, NUM_TAPS, 4, NUM_TAPS, 0, 0, 0, 0, 0, 0, 0, 0);

    rst_n = 1'b0;
    bus.vld = 1'b0; bus.seq_lft = 1'b0; bus.seq_rht = 1'b0; bus.clr_err = 1'b0;
    repeat (3) @(negedge clk);
    outs = 32'({bus.wrt_smpl, bus.coeff_addr, bus.mac_clr, bus.mac_en, bus.res_vld,
                bus.busy, bus.err_ovr, bus.err_sync, bus.err_len});
    check("reset_outputs", outs, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Queue fill: every strobe writes, times out in WAIT and returns to IDLE.
    w0 = n_wrt; m0 = n_mac; r0 = n_res;
    for (int i = 0; i < N_FILL; i++) begin
      @(negedge clk);
      bus.vld = 1'b1;
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk);
        bus.vld = 1'b0;
        if (i == 0 && k == SEQ_TMO)     check("fill_busy_wait", bus.busy, 1);
        if (i == 0 && k == SEQ_TMO + 1) check("fill_busy_tmo", bus.busy, 0);
      end
    end
    #1;
    check("fill_wrt_count", n_wrt - w0, N_FILL);
    check("fill_mac_count", n_mac - m0, 0);
    check("fill_res_count", n_res - r0, 0);
    check("fill_errors", {29'd0, bus.err_ovr, bus.err_sync, bus.err_len}, 0);

    for (int r = 0; r < N_ROWS; r++) run_burst(tbl[r], names[r]);

    // Reset asserted mid-ACC with an overrun flag already set.
    w0 = n_wrt; r0 = n_res;
    @(negedge clk);
    bus.vld = 1'b1;
    for (int k = 1; k <= NUM_TAPS + 8; k++) begin
      @(negedge clk);
      bus.vld     = (k == 300);
      bus.seq_lft = (k >= 2) && (k < NUM_TAPS + 2);
      bus.seq_rht = bus.seq_lft;
      if (k == 500) begin
        check("pre_rst_busy", bus.busy, 1);
        check("pre_rst_ovr", bus.err_ovr, 1);
        rst_n = 1'b0;
        #1;
        outs = 32'({bus.wrt_smpl, bus.coeff_addr, bus.mac_clr, bus.mac_en, bus.res_vld,
                    bus.busy, bus.err_ovr, bus.err_sync, bus.err_len});
        check("rst_mid_acc_outputs", outs, 0);
      end
      if (k == 503) rst_n = 1'b1;
    end
    #1;
    check("rst_wrt_count", n_wrt - w0, 1);
    check("rst_res_count", n_res - r0, 0);
    check("rst_busy_end", bus.busy, 0);

    run_burst(tbl[5], "after_reset");

    repeat (4) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
